ss_array_ctrl: RTL and testbench

Sequencing controller for the 16-bit multiply-accumulate systolic array used by the SS matrix block. It accepts W and X as a serial stream in row-major order and buffers them, then drives the array edges with diagonally skewed data. After the wavefront drains, it reads back the accumulated results and emits them serially. It supports 2x2 and 4x4 operation; the array is always the 4x4 instance, and only its top-left 2x2 is used in small mode.

---
 rtl/ss_pkg.sv | 25 ++
 rtl/ss_array_ctrl_if.sv | 27 ++
 rtl/ss_skew_feeder.sv | 28 ++
 rtl/ss_array_ctrl.sv | 163 ++++++++++++++++
 tb/tb_ss_array_ctrl.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ss_pkg.sv
// Shared constants, state encoding and sizing helpers
// for the SS systolic-array sequencing controller.
package ss_pkg;

   localparam int DW   = 16;
   localparam int AW   = 40;
   localparam int NMAX = 4;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      FEED,
      DRAIN,
      OUT
   } state_t;

   function automatic logic [2:0] dim(input logic size);
      return size ? 3'd4 : 3'd2;
   endfunction

   function automatic logic [5:0] feed_len(input logic [2:0] n);
      return 6'(3 * n) - 6'd2;
   endfunction

endpackage

// File: rtl/ss_array_ctrl_if.sv
// Controller-to-array bus: edge lanes, control strobes
// and the accumulator readback.
interface ss_array_ctrl_if;

   logic                                              arr_clr;
   logic                                              arr_en;
   logic [ss_pkg::NMAX*ss_pkg::DW-1:0]                arr_north;
   logic [ss_pkg::NMAX*ss_pkg::DW-1:0]                arr_west;
   logic [ss_pkg::NMAX*ss_pkg::NMAX*ss_pkg::AW-1:0]   arr_result;

   modport master (
      output arr_clr,
      output arr_en,
      output arr_north,
      output arr_west,
      input  arr_result
   );

   modport slave (
      input  arr_clr,
      input  arr_en,
      input  arr_north,
      input  arr_west,
      output arr_result
   );

endinterface

// File: rtl/ss_skew_feeder.sv
// Diagonal skew of a buffered matrix onto NMAX edge lanes
// for feed cycle t; west selects X rows, else W columns.
module ss_skew_feeder
   import ss_pkg::*;
(
   input  logic [NMAX*NMAX*DW-1:0] mat,
   input  logic [2:0]              n,
   input  logic [3:0]              t,
   input  logic                    west,
   output logic [NMAX*DW-1:0]      lanes
);

   always_comb begin
      int k;
      int idx;
      lanes = '0;
      k     = 0;
      idx   = 0;
      for (int l = 0; l < NMAX; l++) begin
         k = int'(t) - l;
         if (l < int'(n) && k >= 0 && k < int'(n)) begin
            idx = west ? (l * NMAX + k) : (k * NMAX + l);
            lanes[l*DW +: DW] = mat[idx*DW +: DW];
         end
      end
   end

endmodule

// File: rtl/ss_array_ctrl.sv
// Buffers a serial W/X stream, feeds the systolic array
// with skewed edges, then streams the accumulators out.
module ss_array_ctrl
   import ss_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   input  logic [DW-1:0]         matrix,
   input  logic                  matrix_size,
   output logic                  busy,
   ss_array_ctrl_if.master       arr,
   output logic                  out_valid,
   output logic [AW-1:0]         out_value
);

   state_t state_q, state_n;
   logic [5:0] cnt_q, cnt_n;
   logic       size_q;
   logic [2:0] n;
   logic [5:0] nn;
   logic       wr;
   logic       isx;
   logic [5:0] e;
   logic [4:0] waddr;
   logic [3:0] ridx;
   logic       clr_q;

   logic [DW-1:0]           mem [2*NMAX*NMAX];
   logic [NMAX*NMAX*DW-1:0] w_flat, x_flat;
   logic [NMAX*DW-1:0]      north_l, west_l;
   logic [NMAX*DW-1:0]      north_q, west_q;
   logic [AW-1:0]           out_q;

   assign n  = dim(size_q);
   assign nn = size_q ? 6'd16 : 6'd4;

   always_comb begin
      state_n = state_q;
      cnt_n   = cnt_q;
      wr      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_n = LOAD;
               cnt_n   = 6'd1;
               wr      = 1'b1;
            end
         end
         LOAD: begin
            if (in_valid) begin
               wr = 1'b1;
               if (cnt_q == (nn << 1) - 6'd1) begin
                  state_n = FEED;
                  cnt_n   = '0;
               end else begin
                  cnt_n = cnt_q + 6'd1;
               end
            end
         end
         FEED: begin
            if (cnt_q == feed_len(n) - 6'd1) begin
               state_n = DRAIN;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt_q + 6'd1;
            end
         end
         DRAIN: begin
            state_n = OUT;
            cnt_n   = '0;
         end
         OUT: begin
            if (cnt_q == nn - 6'd1) begin
               state_n = IDLE;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt_q + 6'd1;
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   // Beat index splits into W/X half, then row/col by size.
   always_comb begin
      isx = (cnt_q >= nn);
      e   = isx ? (cnt_q - nn) : cnt_q;
      if (size_q)
         waddr = {isx, e[3:2], e[1:0]};
      else
         waddr = {isx, 1'b0, e[1], 1'b0, e[0]};
   end

   always_ff @(posedge clk) begin
      if (wr)
         mem[waddr] <= matrix;
   end

   always_comb begin
      w_flat = '0;
      x_flat = '0;
      for (int i = 0; i < NMAX * NMAX; i++) begin
         w_flat[i*DW +: DW] = mem[i];
         x_flat[i*DW +: DW] = mem[NMAX*NMAX + i];
      end
   end

   ss_skew_feeder u_north (
      .mat   (w_flat),
      .n     (n),
      .t     (cnt_n[3:0]),
      .west  (1'b0),
      .lanes (north_l)
   );

   ss_skew_feeder u_west (
      .mat   (x_flat),
      .n     (n),
      .t     (cnt_n[3:0]),
      .west  (1'b1),
      .lanes (west_l)
   );

   assign ridx = size_q ? cnt_n[3:0]
                        : {1'b0, cnt_n[1], 1'b0, cnt_n[0]};

   // Lanes and result are registered from next-state so
   // they line up with the cycle the state is entered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         size_q  <= 1'b0;
         clr_q   <= 1'b0;
         north_q <= '0;
         west_q  <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_n;
         cnt_q   <= cnt_n;
         clr_q   <= (state_q == IDLE) && in_valid;
         if ((state_q == IDLE) && in_valid)
            size_q <= matrix_size;
         north_q <= (state_n == FEED) ? north_l : '0;
         west_q  <= (state_n == FEED) ? west_l : '0;
         out_q   <= (state_n == OUT)
                    ? arr.arr_result[ridx*AW +: AW] : '0;
      end
   end

   assign busy          = (state_q != IDLE);
   assign arr.arr_clr   = clr_q;
   assign arr.arr_en    = (state_q == FEED);
   assign arr.arr_north = north_q;
   assign arr.arr_west  = west_q;
   assign out_valid     = (state_q == OUT);
   assign out_value     = out_q;

endmodule

// File: tb/tb_ss_array_ctrl.sv
// Scoreboard bench for ss_array_ctrl with a behavioural
// 4x4 MAC array and a plain matrix-product reference.
module tb_ss_array_ctrl;
   import ss_pkg::*;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] matrix = '0;
   logic          matrix_size = 1'b0;
   logic          busy;
   logic          out_valid;
   logic [AW-1:0] out_value;

   ss_array_ctrl_if aif ();

   ss_array_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .matrix      (matrix),
      .matrix_size (matrix_size),
      .busy        (busy),
      .arr         (aif),
      .out_valid   (out_valid),
      .out_value   (out_value)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int runs = 0;
   int clr_total = 0;

   logic [AW-1:0] exp_q [$];
   int            lat_q [$];
   int            feed_q [$];
   logic [DW-1:0] stim [$];

   always @(posedge clk) cyc++;

   // External array: output-stationary PEs, operands
   // pass east/south one hop per enabled cycle.
   logic [AW-1:0] acc [NMAX][NMAX];
   logic [DW-1:0] ar [NMAX][NMAX];
   logic [DW-1:0] br [NMAX][NMAX];

   always @(posedge clk or negedge rst_n) begin
      logic [DW-1:0] a_in, b_in;
      for (int i = 0; i < NMAX; i++)
         for (int j = 0; j < NMAX; j++) begin
            if (!rst_n || aif.arr_clr) begin
               acc[i][j] <= '0;
               ar[i][j]  <= '0;
               br[i][j]  <= '0;
            end else if (aif.arr_en) begin
               if (j == 0) a_in = aif.arr_west[i*DW +: DW];
               else        a_in = ar[i][(j > 0) ? j - 1 : 0];
               if (i == 0) b_in = aif.arr_north[j*DW +: DW];
               else        b_in = br[(i > 0) ? i - 1 : 0][j];
               acc[i][j] <= acc[i][j] + AW'(a_in) * AW'(b_in);
               ar[i][j]  <= a_in;
               br[i][j]  <= b_in;
            end
         end
   end

   always_comb begin
      aif.arr_result = '0;
      for (int i = 0; i < NMAX; i++)
         for (int j = 0; j < NMAX; j++)
            aif.arr_result[(i*NMAX+j)*AW +: AW] = acc[i][j];
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic fail(input string nm);
      checks++;
      errors++;
      $display("FAIL %s: event not as required", nm);
   endtask

   // Monitor: pops expectations whenever the DUT shows them.
   bit prev_ov = 0;
   bit prev_en = 0;
   int en_cnt = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_ov = 0;
         prev_en = 0;
         en_cnt  = 0;
      end else begin
         if (aif.arr_clr) clr_total++;
         if (aif.arr_en) begin
            en_cnt++;
            chk("busy_feed", busy, 1);
         end
         if (!aif.arr_en && prev_en) begin
            if (feed_q.size() == 0) fail("feed_unexpected");
            else chk("feed_len", en_cnt, feed_q.pop_front());
            en_cnt = 0;
         end
         if (!aif.arr_en)
            chk("lanes_idle", (|aif.arr_north) | (|aif.arr_west), 0);
         if (out_valid) begin
            chk("busy_out", busy, 1);
            if (!prev_ov) begin
               if (lat_q.size() == 0) fail("latency_unexpected");
               else chk("latency", cyc, lat_q.pop_front());
            end
            if (exp_q.size() == 0) fail("extra_out");
            else chk("out_value", out_value, exp_q.pop_front());
         end else begin
            chk("out_zero", out_value, 0);
         end
         prev_ov = out_valid;
         prev_en = aif.arr_en;
      end
   end

   task automatic push_ref(input int n);
      int nn = n * n;
      for (int r = 0; r < n; r++)
         for (int c = 0; c < n; c++) begin
            longint s = 0;
            for (int k = 0; k < n; k++)
               s += longint'(stim[nn + r*n + k]) * longint'(stim[k*n + c]);
            exp_q.push_back(AW'(s));
         end
   endtask

   task automatic fill_rand(input int n);
      stim.delete();
      for (int i = 0; i < 2 * n * n; i++)
         stim.push_back(DW'($urandom));
   endtask

   task automatic run(input bit sz, input bit gaps,
                      input bit noise, input bit b2b);
      int n = sz ? 4 : 2;
      int nn = n * n;
      push_ref(n);
      feed_q.push_back(3 * n - 2);
      runs++;
      for (int b = 0; b < 2 * nn; b++) begin
         in_valid    = 1'b1;
         matrix      = stim[b];
         matrix_size = (noise && b > 0) ? 1'($urandom_range(0, 1)) : sz;
         if (b == 2 * nn - 1) lat_q.push_back(cyc + 3 * n);
         @(posedge clk); #1;
         if (gaps && (b == 1 || b == 4)) begin
            in_valid = 1'b0;
            matrix   = DW'($urandom);
            repeat (3) begin @(posedge clk); #1; end
         end
      end
      in_valid = 1'b0;
      if (noise || b2b)
         for (int i = 0; i < 3 * n - 1 + nn; i++) begin
            in_valid    = noise;
            matrix      = DW'($urandom);
            matrix_size = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
         end
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int k = 0;
      while ((busy || exp_q.size() != 0) && k < 400) begin
         @(posedge clk); #1;
         k++;
      end
      if (k >= 400) fail("timeout_idle");
      chk("exp_drained", exp_q.size(), 0);
      chk("lat_drained", lat_q.size(), 0);
      chk("feed_drained", feed_q.size(), 0);
      chk("clr_count", clr_total, runs);
      chk("busy_idle", busy, 0);
   endtask

   initial begin
      bit saw;
      int k;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_value", out_value, 0);
      chk("rst_en", aif.arr_en, 0);
      chk("rst_clr", aif.arr_clr, 0);
      chk("rst_lanes", (|aif.arr_north) | (|aif.arr_west), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      stim = {16'd1, 16'd0, 16'd0, 16'd1, 16'd1, 16'd2, 16'd3, 16'd4};
      run(1'b0, 1'b0, 1'b0, 1'b0);
      wait_idle();

      stim.delete();
      repeat (32) stim.push_back(16'hFFFF);
      run(1'b1, 1'b0, 1'b0, 1'b0);
      wait_idle();

      stim = {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
      run(1'b0, 1'b1, 1'b0, 1'b0);
      wait_idle();

      fill_rand(4);
      run(1'b1, 1'b0, 1'b1, 1'b0);
      wait_idle();
      fill_rand(2);
      run(1'b0, 1'b1, 1'b1, 1'b0);
      wait_idle();

      fill_rand(4);
      run(1'b1, 1'b0, 1'b0, 1'b0);
      k = 0;
      while (!aif.arr_en && k < 50) begin
         @(posedge clk); #1;
         k++;
      end
      if (k >= 50) fail("timeout_feed");
      repeat (3) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_en", aif.arr_en, 0);
      chk("mid_rst_lanes", (|aif.arr_north) | (|aif.arr_west), 0);
      chk("mid_rst_ov", out_valid, 0);
      chk("mid_rst_value", out_value, 0);
      exp_q.delete();
      lat_q.delete();
      feed_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      saw = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (out_valid) saw = 1;
      end
      chk("no_out_after_rst", saw, 0);
      stim = {16'd1, 16'd0, 16'd0, 16'd1, 16'd9, 16'd8, 16'd7, 16'd6};
      run(1'b0, 1'b0, 1'b0, 1'b0);
      wait_idle();

      fill_rand(2);
      run(1'b0, 1'b0, 1'b0, 1'b1);
      fill_rand(4);
      run(1'b1, 1'b0, 1'b0, 1'b1);
      fill_rand(2);
      run(1'b0, 1'b1, 1'b0, 1'b0);
      wait_idle();

      for (int r = 0; r < 4; r++) begin
         bit sz = 1'($urandom_range(0, 1));
         fill_rand(sz ? 4 : 2);
         run(sz, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
         wait_idle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
